// File: rtl/txuart_arbiter.sv
// Round-robin arbiter sharing one txuart between NREQ byte producers, with an optional
// per-requester lock that keeps the grant across multi-byte messages.
module txuart_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ-1:0]   i_lock,
    input  logic [8*NREQ-1:0] i_data,
    output logic [NREQ-1:0]   o_ack,
    output logic [NREQ-1:0]   o_grant,
    output logic              o_tx_enable,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_busy
);

    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam int unsigned SUM_W = PTR_W + 1;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RISE  = 2'd2,
        FALL  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               lock_q, lock_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]    ack_d, grant_d;
    logic               en_d;
    logic [7:0]         data_d;

    logic               lock_hold_c;
    logic [NREQ-1:0]    elig_c;
    logic [SUM_W-1:0]   sum_c;
    logic               win_c;
    logic [PTR_W-1:0]   win_idx_c;
    logic [7:0]         req_data [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_data[g] = i_data[8*g +: 8];
    end

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            cnt_q       <= '0;
            o_ack       <= '0;
            o_grant     <= '0;
            o_tx_enable <= 1'b0;
            o_tx_data   <= 8'h00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            cnt_q       <= cnt_d;
            o_ack       <= ack_d;
            o_grant     <= grant_d;
            o_tx_enable <= en_d;
            o_tx_data   <= data_d;
        end
    end

    // Arbitration scan plus next-state logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        grant_d   = o_grant;
        en_d      = 1'b0;
        data_d    = o_tx_data;
        win_c     = 1'b0;
        win_idx_c = '0;
        sum_c     = '0;

        // o_grant is one-hot on the owner, so it doubles as the lock mask
        lock_hold_c = lock_q && (|(i_lock & o_grant));
        elig_c      = lock_hold_c ? (i_req & o_grant) : i_req;

        for (int unsigned i = 0; i < NREQ; i++) begin
            sum_c = {1'b0, ptr_q} + SUM_W'(i);
            if (sum_c >= SUM_W'(NREQ)) begin
                sum_c = sum_c - SUM_W'(NREQ);
            end
            if (!win_c && elig_c[sum_c[PTR_W-1:0]]) begin
                win_c     = 1'b1;
                win_idx_c = sum_c[PTR_W-1:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (lock_q && !lock_hold_c) begin
                    lock_d = 1'b0;
                end
                if (win_c) begin
                    data_d  = req_data[win_idx_c];
                    grant_d = NREQ'(1) << win_idx_c;
                    ack_d   = NREQ'(1) << win_idx_c;
                    ptr_d   = (win_idx_c == PTR_W'(NREQ - 1)) ? '0 : win_idx_c + PTR_W'(1);
                    lock_d  = i_lock[win_idx_c];
                    en_d    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!i_tx_busy) begin
                    cnt_d   = '0;
                    state_d = RISE;
                end else begin
                    en_d = 1'b1;
                end
            end
            RISE: begin
                if (i_tx_busy) begin
                    state_d = FALL;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FALL: begin
                if (!i_tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_txuart_arbiter.sv
// Directed bench for txuart_arbiter with a small behavioural txuart busy model.
module tb_txuart_arbiter;

    localparam int FRAME = 5;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_busy;

    logic        tx_off;
    int          tx_cnt;
    int          acc_cnt;
    logic [7:0]  acc_last;
    int          cyc;
    int          n_cmp;
    int          n_bad;

    txuart_arbiter #(.NREQ(4), .BUSY_TIMEOUT(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_lock     (lock),
        .i_data     (data),
        .o_ack      (ack),
        .o_grant    (grant),
        .o_tx_enable(tx_en),
        .o_tx_data  (tx_data),
        .i_tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // txuart model: accept on enable while idle, busy for FRAME cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            tx_cnt   <= 0;
            acc_cnt  <= 0;
            acc_last <= 8'h00;
        end else if (!tx_off) begin
            if (tx_busy) begin
                if (tx_cnt == 1) tx_busy <= 1'b0;
                tx_cnt <= tx_cnt - 1;
            end else if (tx_en) begin
                tx_busy  <= 1'b1;
                tx_cnt   <= FRAME;
                acc_cnt  <= acc_cnt + 1;
                acc_last <= tx_data;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        data  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_wait();
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output logic [3:0] a, output int at);
        a  = '0;
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (ack !== 4'b0000) begin
                a  = ack;
                at = cyc;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL ack_timeout: o_ack=%b after 100 cycles, required a nonzero ack", ack);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0; lock = '0; data = '0;
        #1;
        n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL rst_ack: got %b want 0000", ack); end
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL rst_grant: got %b want 0000", grant); end
        n_cmp++; if (tx_en !== 1'b0) begin n_bad++; $display("FAIL rst_enable: got %b want 0", tx_en); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", tx_data); end
    endtask

    task automatic test_single();
        logic [3:0] a;
        int t;
        do_reset();
        data = 32'h0000_4100;
        req  = 4'b0010;
        wait_ack(a, t);
        req = 4'b0000;
        n_cmp++; if (a !== 4'b0010) begin n_bad++; $display("FAIL single_ack: got %b want 0010", a); end
        n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL single_grant: got %b want 0010", grant); end
        n_cmp++; if (tx_en !== 1'b1) begin n_bad++; $display("FAIL single_en_on: got %b want 1", tx_en); end
        n_cmp++; if (tx_data !== 8'h41) begin n_bad++; $display("FAIL single_data: got %h want 41", tx_data); end
        @(posedge clk);
        #1;
        n_cmp++; if (tx_en !== 1'b0) begin n_bad++; $display("FAIL single_en_off: got %b want 0", tx_en); end
        n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
        n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL single_grant_hold: got %b want 0010", grant); end
        idle_wait();
        n_cmp++; if (acc_cnt !== 1) begin n_bad++; $display("FAIL single_accepts: got %0d want 1", acc_cnt); end
        n_cmp++; if (acc_last !== 8'h41) begin n_bad++; $display("FAIL single_accept_byte: got %h want 41", acc_last); end
    endtask

    task automatic test_all_rr();
        logic [3:0] exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] exp_dat [5] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h30};
        logic [3:0] a;
        int t, t_prev;
        do_reset();
        data = 32'h3332_3130;
        req  = 4'b1111;
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ack(a, t);
            if (k == 4) req = 4'b0000;
            n_cmp++; if (a !== exp_ack[k]) begin n_bad++; $display("FAIL rr_ack[%0d]: got %b want %b", k, a, exp_ack[k]); end
            n_cmp++; if (tx_data !== exp_dat[k]) begin n_bad++; $display("FAIL rr_data[%0d]: got %h want %h", k, tx_data, exp_dat[k]); end
            if (k == 1) begin
                n_cmp++; if (t - t_prev !== 8) begin n_bad++; $display("FAIL rr_spacing: got %0d want 8", t - t_prev); end
            end
            t_prev = t;
        end
        idle_wait();
        n_cmp++; if (acc_cnt !== 5) begin n_bad++; $display("FAIL rr_accepts: got %0d want 5", acc_cnt); end
    endtask

    task automatic test_lock();
        logic [3:0] a;
        int t;
        do_reset();
        data = 32'h00A0_0050;
        lock = 4'b0100;
        req  = 4'b0100;
        for (int n = 0; n < 4; n++) begin
            wait_ack(a, t);
            n_cmp++; if (a !== 4'b0100) begin n_bad++; $display("FAIL lock_ack[%0d]: got %b want 0100", n, a); end
            n_cmp++; if (tx_data !== 8'hA0 + 8'(n)) begin n_bad++; $display("FAIL lock_data[%0d]: got %h want %h", n, tx_data, 8'hA0 + 8'(n)); end
            data[23:16] = 8'hA1 + 8'(n);
            req = 4'b0101;
            if (n == 3) begin
                lock = 4'b0000;
                req  = 4'b0001;
            end
        end
        wait_ack(a, t);
        req = 4'b0000;
        n_cmp++; if (a !== 4'b0001) begin n_bad++; $display("FAIL lock_release_ack: got %b want 0001", a); end
        n_cmp++; if (tx_data !== 8'h50) begin n_bad++; $display("FAIL lock_release_data: got %h want 50", tx_data); end
        idle_wait();
    endtask

    task automatic test_timeout();
        logic [3:0] a;
        int t0, t1;
        do_reset();
        tx_off = 1'b1;
        data = 32'h0000_2211;
        req  = 4'b0011;
        wait_ack(a, t0);
        req = 4'b0010;
        n_cmp++; if (a !== 4'b0001) begin n_bad++; $display("FAIL to_first_ack: got %b want 0001", a); end
        @(posedge clk);
        #1;
        n_cmp++; if (tx_en !== 1'b0) begin n_bad++; $display("FAIL to_enable_drop: got %b want 0", tx_en); end
        wait_ack(a, t1);
        req = 4'b0000;
        n_cmp++; if (a !== 4'b0010) begin n_bad++; $display("FAIL to_next_ack: got %b want 0010", a); end
        n_cmp++; if (tx_data !== 8'h22) begin n_bad++; $display("FAIL to_next_data: got %h want 22", tx_data); end
        n_cmp++; if (t1 - t0 !== 6) begin n_bad++; $display("FAIL to_gap: got %0d want 6", t1 - t0); end
        idle_wait();
        tx_off = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] a;
        int t;
        do_reset();
        data = 32'h7700_0055;
        req  = 4'b0001;
        wait_ack(a, t);
        req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (tx_en !== 1'b0) begin n_bad++; $display("FAIL mid_rst_enable: got %b want 0", tx_en); end
        n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_ack: got %b want 0000", ack); end
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_grant: got %b want 0000", grant); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL mid_rst_data: got %h want 00", tx_data); end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1000;
        wait_ack(a, t);
        req = 4'b0000;
        n_cmp++; if (a !== 4'b1000) begin n_bad++; $display("FAIL mid_rst_after_ack: got %b want 1000", a); end
        n_cmp++; if (tx_data !== 8'h77) begin n_bad++; $display("FAIL mid_rst_after_data: got %h want 77", tx_data); end
        idle_wait();
    endtask

    task automatic test_withdraw();
        logic [3:0] a;
        logic [3:0] seen;
        int t;
        do_reset();
        data = 32'h0033_2211;
        req  = 4'b0111;
        wait_ack(a, t);
        req = 4'b0100;
        n_cmp++; if (a !== 4'b0001) begin n_bad++; $display("FAIL wd_first_ack: got %b want 0001", a); end
        wait_ack(a, t);
        req = 4'b0000;
        n_cmp++; if (a !== 4'b0100) begin n_bad++; $display("FAIL wd_next_ack: got %b want 0100", a); end
        n_cmp++; if (tx_data !== 8'h33) begin n_bad++; $display("FAIL wd_next_data: got %h want 33", tx_data); end
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            seen = seen | ack;
        end
        n_cmp++; if (seen !== 4'b0000) begin n_bad++; $display("FAIL wd_no_more_acks: got %b want 0000", seen); end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        cyc    = 0;
        tx_off = 1'b0;
        test_reset();
        test_single();
        test_all_rr();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_withdraw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
